plab4_net_mux: RTL and testbench

//  Merges the two domain-separated ring channels (D1, D2) back into a single

---
 rtl/plab4_net_mux_pkg.sv | 18 +
 rtl/plab4_net_rr_arb2.sv | 33 +++
 rtl/plab4_net_mux.sv | 86 ++++++++
 tb/tb_plab4_net_mux.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/plab4_net_mux_pkg.sv
// Shared definitions for the domain mux slice: message width helper,
// domain tag encodings and the round-robin priority type.
package plab4_net_mux_pkg;

  localparam logic DOMAIN_D1 = 1'b0;
  localparam logic DOMAIN_D2 = 1'b1;

  // Control message = payload + opaque + src + dest
  function automatic int net_msg_nbits(input int pc, input int o, input int s);
    return pc + o + 2 * s;
  endfunction

  typedef enum logic {
    PRIO_D1 = 1'b0,
    PRIO_D2 = 1'b1
  } rr_prio_e;

endpackage

// File: rtl/plab4_net_rr_arb2.sv
// Two-input round-robin arbiter. Grants are one-hot among active requests;
// priority flips to the other input whenever a grant is consumed (en).
module plab4_net_rr_arb2
  import plab4_net_mux_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] reqs,
  input  logic       en,
  output logic [1:0] grants,
  output logic       prio_d2
);

  rr_prio_e prio;

  // Pick the single requester, or the priority holder on a tie
  always_comb begin
    grants = reqs;
    if (reqs == 2'b11)
      grants = (prio == PRIO_D1) ? 2'b01 : 2'b10;
  end

  // Priority moves off whichever input was just served
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      prio <= PRIO_D1;
    else if (en)
      prio <= grants[0] ? PRIO_D2 : PRIO_D1;
  end

  assign prio_d2 = (prio == PRIO_D2);

endmodule

// File: rtl/plab4_net_mux.sv
// Merges the D1/D2 ring channels into one domain-tagged val/rdy channel
// through a single registered output stage that is zeroed whenever idle.
module plab4_net_mux
  import plab4_net_mux_pkg::*;
#(
  parameter  int p_payload_cnbits = 32,
  parameter  int p_payload_dnbits = 32,
  parameter  int p_opaque_nbits   = 3,
  parameter  int p_srcdest_nbits  = 3,
  localparam int c_net_msg_cnbits =
    net_msg_nbits(p_payload_cnbits, p_opaque_nbits, p_srcdest_nbits)
)(
  input  logic                        clk,
  input  logic                        reset,

  input  logic                        in_val_d1,
  output logic                        in_rdy_d1,
  input  logic [c_net_msg_cnbits-1:0] in_msg_control_d1,
  input  logic [p_payload_dnbits-1:0] in_msg_data_d1,

  input  logic                        in_val_d2,
  output logic                        in_rdy_d2,
  input  logic [c_net_msg_cnbits-1:0] in_msg_control_d2,
  input  logic [p_payload_dnbits-1:0] in_msg_data_d2,

  output logic                        out_val,
  input  logic                        out_rdy,
  output logic [c_net_msg_cnbits-1:0] out_msg_control,
  output logic [p_payload_dnbits-1:0] out_msg_data,
  output logic                        out_domain
);

  logic                        val_p1;
  logic                        dom_p1;
  logic [c_net_msg_cnbits-1:0] ctrl_p1;
  logic [p_payload_dnbits-1:0] data_p1;

  logic       stage_free;
  logic       prio_d2;
  logic [1:0] grants;
  logic       accept;

  plab4_net_rr_arb2 arb (
    .clk     (clk),
    .reset   (reset),
    .reqs    ({in_val_d2, in_val_d1}),
    .en      (accept),
    .grants  (grants),
    .prio_d2 (prio_d2)
  );

  // ---- stage p0: arbitration and ready gating ----
  // Ready of each port looks only at the other port's valid and the
  // priority, so no combinational val->rdy loop forms on the same port.
  assign stage_free = !val_p1 || out_rdy;
  assign in_rdy_d1  = stage_free && (!in_val_d2 || !prio_d2);
  assign in_rdy_d2  = stage_free && (!in_val_d1 ||  prio_d2);
  assign accept     = (grants[0] && in_rdy_d1) || (grants[1] && in_rdy_d2);

  // ---- stage p1: output register ----
  // Load on accept, zero on drain with no refill, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_p1  <= 1'b0;
      dom_p1  <= DOMAIN_D1;
      ctrl_p1 <= '0;
      data_p1 <= '0;
    end else if (accept) begin
      val_p1  <= 1'b1;
      dom_p1  <= grants[1] ? DOMAIN_D2 : DOMAIN_D1;
      ctrl_p1 <= grants[1] ? in_msg_control_d2 : in_msg_control_d1;
      data_p1 <= grants[1] ? in_msg_data_d2    : in_msg_data_d1;
    end else if (stage_free) begin
      val_p1  <= 1'b0;
      dom_p1  <= DOMAIN_D1;
      ctrl_p1 <= '0;
      data_p1 <= '0;
    end
  end

  assign out_val         = val_p1;
  assign out_domain      = dom_p1;
  assign out_msg_control = ctrl_p1;
  assign out_msg_data    = data_p1;

endmodule

// File: tb/tb_plab4_net_mux.sv
// Bench for plab4_net_mux: directed scenarios with literal expectations,
// then randomized traffic against a behavioural model and per-domain queues.
module tb_plab4_net_mux;

  localparam int M = 41;

  typedef struct packed {
    logic [M-1:0] c;
    logic [31:0]  d;
  } msg_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_val_d1, in_rdy_d1, in_val_d2, in_rdy_d2;
  logic [M-1:0]  in_msg_control_d1, in_msg_control_d2;
  logic [31:0]   in_msg_data_d1, in_msg_data_d2;
  logic          out_val, out_rdy, out_domain;
  logic [M-1:0]  out_msg_control;
  logic [31:0]   out_msg_data;

  plab4_net_mux dut (
    .clk               (clk),
    .reset             (reset),
    .in_val_d1         (in_val_d1),
    .in_rdy_d1         (in_rdy_d1),
    .in_msg_control_d1 (in_msg_control_d1),
    .in_msg_data_d1    (in_msg_data_d1),
    .in_val_d2         (in_val_d2),
    .in_rdy_d2         (in_rdy_d2),
    .in_msg_control_d2 (in_msg_control_d2),
    .in_msg_data_d2    (in_msg_data_d2),
    .out_val           (out_val),
    .out_rdy           (out_rdy),
    .out_msg_control   (out_msg_control),
    .out_msg_data      (out_msg_data),
    .out_domain        (out_domain)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: the held message (if any) and which domain was served last.
  logic         m_val;
  logic         m_dom;
  logic [M-1:0] m_ctrl;
  logic [31:0]  m_data;
  logic         last_served;   // 1 means D2 served last, so D1 wins a tie
  msg_t         q1[$];
  msg_t         q2[$];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    m_val = 1'b0;
    m_dom = 1'b0;
    m_ctrl = '0;
    m_data = '0;
  endfunction

  function automatic void model_reset();
    model_clear();
    last_served = 1'b1;
    q1.delete();
    q2.delete();
  endfunction

  // One clock cycle: drive inputs, check outputs/readies, advance model.
  task automatic step(input logic v1, input logic [M-1:0] c1, input logic [31:0] d1,
                      input logic v2, input logic [M-1:0] c2, input logic [31:0] d2,
                      input logic ordy, output logic a1, output logic a2);
    logic free, e1, e2;
    msg_t mm;
    in_val_d1 = v1; in_msg_control_d1 = c1; in_msg_data_d1 = d1;
    in_val_d2 = v2; in_msg_control_d2 = c2; in_msg_data_d2 = d2;
    out_rdy = ordy;
    #1;
    check("out_val", 64'(out_val), 64'(m_val));
    check("out_domain", 64'(out_domain), 64'(m_dom));
    check("out_msg_control", 64'(out_msg_control), 64'(m_ctrl));
    check("out_msg_data", 64'(out_msg_data), 64'(m_data));
    if (!out_val) check("idle_scrub", 64'(out_msg_data), 64'd0);
    free = !m_val || ordy;
    e1 = free && (!v2 || last_served == 1'b1);
    e2 = free && (!v1 || last_served == 1'b0);
    check("in_rdy_d1", 64'(in_rdy_d1), 64'(e1));
    check("in_rdy_d2", 64'(in_rdy_d2), 64'(e2));
    if (m_val && ordy) begin
      if ((m_dom ? q2.size() : q1.size()) == 0) begin
        check("sb_nonempty", 64'd0, 64'd1);
      end else begin
        mm = m_dom ? q2.pop_front() : q1.pop_front();
        check("sb_ctrl", 64'(out_msg_control), 64'(mm.c));
        check("sb_data", 64'(out_msg_data), 64'(mm.d));
      end
    end
    a1 = v1 && e1;
    a2 = v2 && e2;
    @(posedge clk);
    if (a1 || a2) begin
      m_val = 1'b1;
      m_dom = a2;
      m_ctrl = a2 ? c2 : c1;
      m_data = a2 ? d2 : d1;
      last_served = a2;
      if (a2) q2.push_back('{c: c2, d: d2});
      else    q1.push_back('{c: c1, d: d1});
    end else if (free) begin
      model_clear();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_val_d1 = 1'b0; in_val_d2 = 1'b0; out_rdy = 1'b0;
    in_msg_control_d1 = '0; in_msg_control_d2 = '0;
    in_msg_data_d1 = '0; in_msg_data_d2 = '0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic a1, a2;
    logic cv1, cv2, cr;
    logic [M-1:0] cc1, cc2;
    logic [31:0] cd1, cd2;
    logic [M-1:0] z;
    z = '0;

    @(negedge clk);
    do_reset();
    check("rst_out_val", 64'(out_val), 64'd0);
    check("rst_out_data", 64'(out_msg_data), 64'd0);

    // Async reset while a message is held
    step(1'b1, 41'h15, 32'h12345678, 1'b0, z, 32'd0, 1'b0, a1, a2);
    check("t1_held_val", 64'(out_val), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t1_async_val", 64'(out_val), 64'd0);
    check("t1_async_ctrl", 64'(out_msg_control), 64'd0);
    check("t1_async_data", 64'(out_msg_data), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 41'h21, 32'h1, 1'b1, 41'h22, 32'h2, 1'b1, a1, a2);
    check("t1_first_grant_dom", 64'(out_domain), 64'd0);
    check("t1_first_grant_data", 64'(out_msg_data), 64'h1);

    // Single D1 message, then idle scrub
    do_reset();
    step(1'b1, 41'h15, 32'hDEADBEEF, 1'b0, z, 32'd0, 1'b1, a1, a2);
    check("t2_val", 64'(out_val), 64'd1);
    check("t2_dom", 64'(out_domain), 64'd0);
    check("t2_data", 64'(out_msg_data), 64'hDEADBEEF);
    check("t2_ctrl", 64'(out_msg_control), 64'h15);
    step(1'b0, z, 32'd0, 1'b0, z, 32'd0, 1'b1, a1, a2);
    check("t2_idle_val", 64'(out_val), 64'd0);
    check("t2_idle_data", 64'(out_msg_data), 64'd0);

    // Both valid: strict alternation at full rate
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 41'(i), 32'hA0000000 + 32'(i), 1'b1, 41'(i), 32'hB0000000 + 32'(i),
           1'b1, a1, a2);
      check("t3_val", 64'(out_val), 64'd1);
      check("t3_dom", 64'(out_domain), 64'(i % 2));
    end
    step(1'b0, z, 32'd0, 1'b0, z, 32'd0, 1'b1, a1, a2);

    // Backpressure holds D2 message, then drain+refill from D1
    do_reset();
    step(1'b0, z, 32'd0, 1'b1, 41'h7, 32'hCAFE0001, 1'b0, a1, a2);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 41'h9, 32'h11111111, 1'b0, z, 32'd0, 1'b0, a1, a2);
      check("t4_rdy_d1", 64'(in_rdy_d1), 64'd0);
      check("t4_rdy_d2", 64'(in_rdy_d2), 64'd0);
      check("t4_dom", 64'(out_domain), 64'd1);
      check("t4_data", 64'(out_msg_data), 64'hCAFE0001);
    end
    step(1'b1, 41'h9, 32'h11111111, 1'b0, z, 32'd0, 1'b1, a1, a2);
    check("t4_refill_val", 64'(out_val), 64'd1);
    check("t4_refill_dom", 64'(out_domain), 64'd0);
    check("t4_refill_data", 64'(out_msg_data), 64'h11111111);
    step(1'b0, z, 32'd0, 1'b0, z, 32'd0, 1'b1, a1, a2);

    // Priority moves off D2 after D2-only traffic
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b0, z, 32'd0, 1'b1, 41'(i), 32'h200 + 32'(i), 1'b1, a1, a2);
    step(1'b1, 41'h31, 32'h300, 1'b1, 41'h32, 32'h301, 1'b1, a1, a2);
    check("t5_dom", 64'(out_domain), 64'd0);
    check("t5_data", 64'(out_msg_data), 64'h300);
    step(1'b0, z, 32'd0, 1'b0, z, 32'd0, 1'b1, a1, a2);

    // Randomized traffic; an offered message stays put until accepted
    do_reset();
    cv1 = 1'b0; cv2 = 1'b0; a1 = 1'b0; a2 = 1'b0;
    cc1 = '0; cc2 = '0; cd1 = '0; cd2 = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!cv1 || a1) begin
        cv1 = ($urandom_range(0, 3) != 0);
        cc1 = M'({$urandom(), $urandom()});
        cd1 = $urandom();
      end
      if (!cv2 || a2) begin
        cv2 = ($urandom_range(0, 3) != 0);
        cc2 = M'({$urandom(), $urandom()});
        cd2 = $urandom();
      end
      cr = ($urandom_range(0, 3) != 0);
      step(cv1, cc1, cd1, cv2, cc2, cd2, cr, a1, a2);
    end
    // Drain whatever is still held
    for (int i = 0; i < 3; i++)
      step(1'b0, z, 32'd0, 1'b0, z, 32'd0, 1'b1, a1, a2);
    check("sb_q1_empty", 64'(q1.size()), 64'd0);
    check("sb_q2_empty", 64'(q2.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
